// File: rtl/maze_move_tracker.sv
// Purpose  : tracks a position on a 2^N x 2^N grid driven by MOVE/BACK/LOAD/CLEAR commands,
//            and keeps a LIFO of applied MOVE directions so that BACK can retrace them.
// Latency  : command accepted in IDLE, results committed 2 edges later, done pulses 1 cycle.
// Backpress: cmd_ready is high only in IDLE; one command per 3 cycles at most.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   cmd_valid/cmd_ready request handshake; cmd_op/cmd_dir/load_x/load_y captured on accept
//   x, y                registered current position
//   done, invalid       completion pulse; invalid qualifies done (command rejected)
//   last_dir            direction applied by the last completed MOVE or BACK
//   empty, full         registered LIFO occupancy flags
module maze_move_tracker #(
    parameter int N     = 4,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [1:0]   cmd_dir,
    input  logic [N-1:0] load_x,
    input  logic [N-1:0] load_y,
    output logic [N-1:0] x,
    output logic [N-1:0] y,
    output logic         done,
    output logic         invalid,
    output logic [1:0]   last_dir,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [N-1:0]  POS_MAX = {N{1'b1}};
    localparam logic [N-1:0]  POS_ONE = N'(1);
    localparam logic [N-1:0]  POS_MIN = '0;

    localparam logic [1:0] OP_MOVE  = 2'b00;
    localparam logic [1:0] OP_BACK  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state_q, state_d;

    // command captured at the accept edge
    logic [1:0]    op_q, op_d;
    logic [1:0]    dir_q, dir_d;
    logic [N-1:0]  ldx_q, ldx_d;
    logic [N-1:0]  ldy_q, ldy_d;

    // architectural results
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          inv_q, inv_d;
    logic [1:0]    last_q, last_d;

    // direction history; contents need no reset, cnt_q says what is valid
    logic [1:0]    stack_q [DEPTH];
    logic          push_en;

    // ------------------------------------------------------------------
    // Step evaluation shared by MOVE and BACK
    // ------------------------------------------------------------------
    logic [AW-1:0] top_idx;
    logic [1:0]    top_dir;
    logic [1:0]    step_dir;
    logic [N-1:0]  step_x;
    logic [N-1:0]  step_y;
    logic          step_ok;

    // top of stack sits one below the count; when the stack is full the
    // low AW bits of the count wrap to zero so the subtraction still lands
    // on the last slot
    assign top_idx = cnt_q[AW-1:0] - AW'(1);
    assign top_dir = stack_q[top_idx];

    // flipping bit 1 of a direction code gives the opposite direction
    assign step_dir = (op_q == OP_BACK) ? (top_dir ^ 2'b10) : dir_q;

    always_comb begin
        step_x  = x_q;
        step_y  = y_q;
        step_ok = 1'b1;
        case (step_dir)
            DIR_UP: begin
                if (y_q == POS_MIN) step_ok = 1'b0;
                else                step_y  = y_q - POS_ONE;
            end
            DIR_RIGHT: begin
                if (x_q == POS_MAX) step_ok = 1'b0;
                else                step_x  = x_q + POS_ONE;
            end
            DIR_DOWN: begin
                if (y_q == POS_MAX) step_ok = 1'b0;
                else                step_y  = y_q + POS_ONE;
            end
            default: begin
                if (x_q == POS_MIN) step_ok = 1'b0;
                else                step_x  = x_q - POS_ONE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dir_d     = dir_q;
        ldx_d     = ldx_q;
        ldy_d     = ldy_q;
        x_d       = x_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        inv_d     = inv_q;
        last_d    = last_q;
        push_en   = 1'b0;
        cmd_ready = (state_q == S_IDLE);
        done      = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    dir_d   = cmd_dir;
                    ldx_d   = load_x;
                    ldy_d   = load_y;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                state_d = S_DONE;
                case (op_q)
                    OP_MOVE: begin
                        if (!step_ok || full_q) begin
                            inv_d = 1'b1;
                        end else begin
                            inv_d   = 1'b0;
                            x_d     = step_x;
                            y_d     = step_y;
                            cnt_d   = cnt_q + CNT_ONE;
                            push_en = 1'b1;
                            last_d  = dir_q;
                        end
                    end
                    OP_BACK: begin
                        // a popped move was legal when made, so its reverse
                        // is always in range
                        if (empty_q) begin
                            inv_d = 1'b1;
                        end else begin
                            inv_d  = 1'b0;
                            x_d    = step_x;
                            y_d    = step_y;
                            cnt_d  = cnt_q - CNT_ONE;
                            last_d = step_dir;
                        end
                    end
                    OP_LOAD: begin
                        inv_d = 1'b0;
                        x_d   = ldx_q;
                        y_d   = ldy_q;
                        cnt_d = '0;
                    end
                    OP_CLEAR: begin
                        inv_d = 1'b0;
                        cnt_d = '0;
                    end
                    default: begin
                        inv_d = inv_q;
                    end
                endcase
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // flags derived from the next count so the registered copies always
        // agree with the registered count
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == DEPTH_C);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_MOVE;
            dir_q   <= DIR_UP;
            ldx_q   <= '0;
            ldy_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            inv_q   <= 1'b0;
            last_q  <= DIR_UP;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dir_q   <= dir_d;
            ldx_q   <= ldx_d;
            ldy_q   <= ldy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            inv_q   <= inv_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            stack_q[cnt_q[AW-1:0]] <= dir_q;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign invalid  = inv_q;
    assign last_dir = last_q;
    assign empty    = empty_q;
    assign full     = full_q;

endmodule

// File: tb/tb_maze_move_tracker.sv
// Purpose  : self-checking bench for maze_move_tracker (N=4, DEPTH=4).
// Latency  : model commits a command two edges after acceptance, done lasts one cycle.
// Backpress: requests are held until cmd_ready is seen high.
module tb_maze_move_tracker;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int MAXC  = 15;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [1:0]   cmd_dir = 2'b00;
    logic [N-1:0] load_x = '0;
    logic [N-1:0] load_y = '0;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         done;
    logic         invalid;
    logic [1:0]   last_dir;
    logic         empty;
    logic         full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    maze_move_tracker #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dir   (cmd_dir),
        .load_x    (load_x),
        .load_y    (load_y),
        .x         (x),
        .y         (y),
        .done      (done),
        .invalid   (invalid),
        .last_dir  (last_dir),
        .empty     (empty),
        .full      (full)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: grid position as integers, history as a queue,
    // timing as "cycles since acceptance".
    // ------------------------------------------------------------------
    int m_x = 0;
    int m_y = 0;
    int m_stk[$];
    int m_last = 0;
    int m_inv = 0;
    int m_age = 0;    // 0: free, 1: executing, 2: done cycle
    bit m_done = 1'b0;
    bit m_live = 1'b0;
    int p_op, p_dir, p_lx, p_ly;

    function automatic int dxf(input int d);
        return (d == 1) ? 1 : ((d == 3) ? -1 : 0);
    endfunction

    function automatic int dyf(input int d);
        return (d == 2) ? 1 : ((d == 0) ? -1 : 0);
    endfunction

    task automatic model_apply();
        int nx, ny, d, o;
        case (p_op)
            0: begin
                nx = m_x + dxf(p_dir);
                ny = m_y + dyf(p_dir);
                if (nx < 0 || nx > MAXC || ny < 0 || ny > MAXC || m_stk.size() == DEPTH) begin
                    m_inv = 1;
                end else begin
                    m_inv = 0;
                    m_x = nx;
                    m_y = ny;
                    m_stk.push_back(p_dir);
                    m_last = p_dir;
                end
            end
            1: begin
                if (m_stk.size() == 0) begin
                    m_inv = 1;
                end else begin
                    d = m_stk.pop_back();
                    o = (d + 2) % 4;
                    m_x = m_x + dxf(o);
                    m_y = m_y + dyf(o);
                    m_last = o;
                    m_inv = 0;
                end
            end
            2: begin
                m_x = p_lx;
                m_y = p_ly;
                m_stk.delete();
                m_inv = 0;
            end
            default: begin
                m_stk.delete();
                m_inv = 0;
            end
        endcase
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_x = 0; m_y = 0; m_stk.delete(); m_last = 0; m_inv = 0;
            m_age = 0; m_done = 1'b0; m_live = 1'b1;
        end else if (m_age == 0) begin
            m_done = 1'b0;
            if (cmd_valid) begin
                p_op = int'(cmd_op); p_dir = int'(cmd_dir);
                p_lx = int'(load_x); p_ly = int'(load_y);
                m_age = 1;
            end
        end else if (m_age == 1) begin
            model_apply();
            m_done = 1'b1;
            m_age = 2;
        end else begin
            m_done = 1'b0;
            m_age = 0;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("cmd_ready", int'(cmd_ready), int'(m_age == 0));
            chk("done",      int'(done),      int'(m_done));
            chk("x",         int'(x),         m_x);
            chk("y",         int'(y),         m_y);
            chk("empty",     int'(empty),     int'(m_stk.size() == 0));
            chk("full",      int'(full),      int'(m_stk.size() == DEPTH));
            if (m_done) begin
                chk("invalid",  int'(invalid),  m_inv);
                chk("last_dir", int'(last_dir), m_last);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic issue(input int op, input int dir, input int lx, input int ly);
        int n;
        n = 0;
        while (!cmd_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("accept_timeout", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_dir   = 2'(dir);
        load_x    = N'(lx);
        load_y    = N'(ly);
        @(negedge clk);
        // later input changes must not affect the accepted command
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(3));
        cmd_dir   = 2'($urandom_range(3));
        load_x    = N'($urandom_range(MAXC));
        load_y    = N'($urandom_range(MAXC));
        n = 0;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", int'(done), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int mv_dir[4] = '{1, 2, 3, 2};
        int mv_x[4]   = '{6, 6, 5, 5};
        int mv_y[4]   = '{5, 6, 6, 7};
        int bk_x[4]   = '{5, 6, 6, 5};
        int bk_y[4]   = '{6, 6, 5, 5};
        int rdy_seen, dones;
        int rdy_exp[9] = '{1, 0, 0, 1, 0, 0, 1, 0, 0};

        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_x",        int'(x),         0);
        chk("rst_y",        int'(y),         0);
        chk("rst_empty",    int'(empty),     1);
        chk("rst_full",     int'(full),      0);
        chk("rst_ready",    int'(cmd_ready), 1);
        chk("rst_done",     int'(done),      0);
        chk("rst_invalid",  int'(invalid),   0);
        chk("rst_last_dir", int'(last_dir),  0);

        // off the top edge, then a legal step right
        issue(0, 0, 0, 0);
        chk("up_edge_invalid", int'(invalid), 1);
        chk("up_edge_y",       int'(y),       0);
        issue(0, 1, 0, 0);
        chk("right_x",        int'(x),        1);
        chk("right_invalid",  int'(invalid),  0);
        chk("right_last_dir", int'(last_dir), 1);
        chk("right_empty",    int'(empty),    0);

        // LOAD keeps last_dir, empties the history
        issue(2, 0, 5, 5);
        chk("load_x",        int'(x),        5);
        chk("load_empty",    int'(empty),    1);
        chk("load_last_dir", int'(last_dir), 1);

        for (int i = 0; i < 4; i++) begin
            issue(0, mv_dir[i], 0, 0);
            chk("walk_x", int'(x), mv_x[i]);
            chk("walk_y", int'(y), mv_y[i]);
        end
        chk("walk_full", int'(full), 1);
        issue(0, 1, 0, 0);
        chk("full_invalid", int'(invalid), 1);
        chk("full_x",       int'(x),       5);
        chk("full_y",       int'(y),       7);

        for (int i = 0; i < 4; i++) begin
            issue(1, 0, 0, 0);
            chk("back_x", int'(x), bk_x[i]);
            chk("back_y", int'(y), bk_y[i]);
        end
        chk("back_last_dir", int'(last_dir), 3);
        chk("back_empty",    int'(empty),    1);
        issue(1, 0, 0, 0);
        chk("back_empty_invalid", int'(invalid), 1);

        // bottom-right corner
        issue(2, 0, 15, 15);
        issue(0, 1, 0, 0);
        chk("corner_right_invalid", int'(invalid), 1);
        issue(0, 2, 0, 0);
        chk("corner_down_invalid", int'(invalid), 1);
        issue(0, 3, 0, 0);
        chk("corner_left_x", int'(x), 14);
        chk("corner_left_y", int'(y), 15);

        // CLEAR keeps position, then BACK has nothing to undo
        issue(3, 0, 0, 0);
        chk("clear_empty",   int'(empty),   1);
        chk("clear_x",       int'(x),       14);
        chk("clear_invalid", int'(invalid), 0);
        issue(1, 0, 0, 0);
        chk("clear_back_invalid", int'(invalid), 1);
        issue(0, 3, 0, 3);
        issue(2, 0, 0, 3);
        issue(0, 3, 0, 0);
        chk("left_edge_invalid", int'(invalid), 1);

        // continuous request: 1 accept every 3 cycles
        issue(2, 0, 8, 8);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_dir   = 2'b01;
        dones     = 0;
        for (int i = 0; i < 9; i++) begin
            rdy_seen = int'(cmd_ready);
            chk("stream_ready", rdy_seen, rdy_exp[i]);
            if (done) dones++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("stream_dones", dones, 3);
        chk("stream_x",     int'(x), 11);

        // reset while a MOVE is executing
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_dir   = 2'b00;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        chk("mid_rst_x",     int'(x),     0);
        chk("mid_rst_y",     int'(y),     0);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_done",  int'(done),  0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_no_done", int'(done), 0);
            @(negedge clk);
        end
        chk("post_rst_ready", int'(cmd_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
